// File: rtl/dialogue_pkg.sv
// Shared constants and types for the board-to-board dialogue link.
package dialogue_pkg;

    // Link framing: a byte travels as SYMS_PER_FRAME symbols of SYM_W bits.
    localparam int SYM_W          = 2;
    localparam int SYMS_PER_FRAME = 4;
    localparam int BYTE_W         = SYM_W * SYMS_PER_FRAME;

    // Default parameter values for dialogue_link.
    localparam int DEF_HOLD_CYCLES = 4;
    localparam int DEF_TIMEOUT     = 64;
    localparam int DEF_FIFO_DEPTH  = 4;

    // Transmit sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } tx_state_t;

endpackage

// File: rtl/dialogue_fifo.sv
// Small synchronous FIFO used as the transmit byte queue.
// Head data is presented combinationally (first-word fall-through).
module dialogue_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_do_push;
    logic              w_do_pop;

    // Full/empty come from the registered count only, so a same-cycle pop
    // can never open room for a push into a full queue.
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage write.
    // NOTE: the data array has no reset; pointers and count define validity,
    // and leaving it unreset lets it map onto plain RAM/register cells.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dialogue_link.sv
// Serial dialogue link between two game boards. Bytes are queued, split into
// 2-bit symbols and sent with a toggling strobe; the receiver synchronizes the
// partner's lines, reassembles bytes and discards stale partial frames.
module dialogue_link
    import dialogue_pkg::*;
#(
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [SYM_W:0]    dialogue_out,
    input  logic [SYM_W:0]    dialogue_in,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_err,
    output logic              link_busy
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [9:0] TO_LAST   = 10'(TIMEOUT - 1);
    localparam logic [1:0] LAST_SYM  = 2'(SYMS_PER_FRAME - 1);
    localparam int         ASM_W     = BYTE_W - SYM_W;

    // ------------------------------------------------------------------
    // Transmit queue
    // ------------------------------------------------------------------
    logic [BYTE_W-1:0]            w_fifo_dout;
    logic                         w_full;
    logic                         w_empty;
    logic [$clog2(FIFO_DEPTH):0]  w_count;
    logic                         w_pop;

    dialogue_fifo #(
        .DATA_W (BYTE_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (tx_valid),
        .i_data  (tx_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign tx_ready = !w_full;

    // ------------------------------------------------------------------
    // Transmit sequencer
    // ------------------------------------------------------------------
    tx_state_t         r_state;
    tx_state_t         w_state_nxt;
    logic              w_next_sym;
    logic [BYTE_W-1:0] r_shift;
    logic [SYM_W-1:0]  r_sym;
    logic              r_strobe;
    logic [1:0]        r_sym_idx;
    logic [7:0]        r_hold_cnt;

    // TX state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // TX next-state and control decode. The last HOLD cycle of a byte pops
    // the next byte directly, so back-to-back bytes leave no idle gap.
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_next_sym  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_STROBE;
            end
            ST_STROBE: begin
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (r_hold_cnt == HOLD_LAST) begin
                    if (r_sym_idx != LAST_SYM) begin
                        w_next_sym  = 1'b1;
                        w_state_nxt = ST_SETUP;
                    end else if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_SETUP;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // TX datapath: symbol shifter, strobe toggle and hold timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_sym      <= '0;
            r_strobe   <= 1'b0;
            r_sym_idx  <= '0;
            r_hold_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_sym     <= w_fifo_dout[BYTE_W-1 -: SYM_W];
                r_shift   <= {w_fifo_dout[BYTE_W-SYM_W-1:0], {SYM_W{1'b0}}};
                r_sym_idx <= '0;
            end else if (w_next_sym) begin
                r_sym     <= r_shift[BYTE_W-1 -: SYM_W];
                r_shift   <= {r_shift[BYTE_W-SYM_W-1:0], {SYM_W{1'b0}}};
                r_sym_idx <= r_sym_idx + 2'd1;
            end
            // Symbol is already stable for one cycle when the strobe flips.
            if (r_state == ST_SETUP) begin
                r_strobe <= ~r_strobe;
            end
            if (r_state == ST_STROBE) begin
                r_hold_cnt <= '0;
            end else if (r_state == ST_HOLD) begin
                r_hold_cnt <= r_hold_cnt + 8'd1;
            end
        end
    end

    assign dialogue_out = {r_strobe, r_sym};
    assign link_busy    = (r_state != ST_IDLE) || (w_count != '0);

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [SYM_W:0]    r_sync1;
    logic [SYM_W:0]    r_sync2;
    logic              r_sync3;
    logic              w_toggle;
    logic              w_timeout;
    logic [ASM_W-1:0]  r_asm;
    logic [BYTE_W-1:0] w_asm_nxt;
    logic [1:0]        r_rx_cnt;
    logic [9:0]        r_idle_cnt;
    logic [BYTE_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_rx_err;

    // Two-flop synchronizer on all lines, plus a delayed copy of the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= dialogue_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2[SYM_W];
        end
    end

    assign w_toggle  = r_sync2[SYM_W] ^ r_sync3;
    assign w_timeout = (r_rx_cnt != 2'd0) && (r_idle_cnt == TO_LAST);
    assign w_asm_nxt = {r_asm, r_sync2[SYM_W-1:0]};

    // Frame assembly, completion and stale-frame discard. A toggle landing
    // on the timeout cycle still reports the discard but starts a new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_asm      <= '0;
            r_rx_cnt   <= '0;
            r_idle_cnt <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
            if (w_toggle) begin
                r_idle_cnt <= '0;
                r_asm      <= w_asm_nxt[ASM_W-1:0];
                if (w_timeout) begin
                    r_rx_err <= 1'b1;
                    r_rx_cnt <= 2'd1;
                end else if (r_rx_cnt == LAST_SYM) begin
                    r_rx_data  <= w_asm_nxt;
                    r_rx_valid <= 1'b1;
                    r_rx_cnt   <= '0;
                end else begin
                    r_rx_cnt <= r_rx_cnt + 2'd1;
                end
            end else if (w_timeout) begin
                r_rx_err   <= 1'b1;
                r_rx_cnt   <= '0;
                r_idle_cnt <= '0;
            end else if (r_rx_cnt != 2'd0) begin
                r_idle_cnt <= r_idle_cnt + 10'd1;
            end
        end
    end

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign rx_err   = r_rx_err;

endmodule

// File: tb/tb_dialogue_link.sv
// Directed self-checking bench for dialogue_link with default parameters.
module tb_dialogue_link;

    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [2:0] dialogue_out;
    logic [2:0] dialogue_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic       link_busy;

    logic       loop_en = 1'b1;
    logic [2:0] drv = 3'b000;

    assign dialogue_in = loop_en ? dialogue_out : drv;

    dialogue_link #(
        .HOLD_CYCLES (4),
        .TIMEOUT     (TO),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .dialogue_out (dialogue_out),
        .dialogue_in  (dialogue_in),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_err       (rx_err),
        .link_busy    (link_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int         c;
        logic [7:0] d;
    } ev_t;

    ev_t  rxq[$];
    ev_t  tgq[$];
    int   errq[$];
    logic prev_strobe = 1'b0;

    // Event monitor: received bytes, error pulses and transmit strobe toggles.
    always @(negedge clk) begin
        ev_t ev;
        if (rx_valid) begin
            ev.c = cyc; ev.d = rx_data; rxq.push_back(ev);
        end
        if (rx_err) errq.push_back(cyc);
        if (dialogue_out[2] !== prev_strobe) begin
            ev.c = cyc; ev.d = {6'b0, dialogue_out[1:0]}; tgq.push_back(ev);
        end
        prev_strobe = dialogue_out[2];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic clear_mon();
        rxq.delete(); tgq.delete(); errq.delete();
    endtask

    task automatic push(input logic [7:0] b, output int t);
        int k = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && k < 300) begin
            @(negedge clk); k++;
        end
        @(posedge clk);
        @(negedge clk);
        t = cyc;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rxq.size() < n && k < budget) begin
            @(negedge clk); k++;
        end
    endtask

    task automatic send_sym(input logic [1:0] s, output int t);
        @(negedge clk); drv[1:0] = s;
        @(negedge clk); drv[2] = ~drv[2]; t = cyc;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (tx_ready !== 1'b1) $display("FAIL rst_tx_ready: got %b want 1", tx_ready); else n_pass++;
        n_checks++; if (dialogue_out !== 3'b000) $display("FAIL rst_dialogue_out: got %b want 000", dialogue_out); else n_pass++;
        n_checks++; if (rx_data !== 8'h00) $display("FAIL rst_rx_data: got %h want 00", rx_data); else n_pass++;
        n_checks++; if ({rx_valid, rx_err, link_busy} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {rx_valid, rx_err, link_busy}); else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        logic [1:0] exp_sym [4] = '{2'b10, 2'b10, 2'b01, 2'b01};
        int p;
        clear_mon();
        push(8'hA5, p);
        tx_valid = 1'b0;
        wait_rx(1, 100);
        repeat (10) @(negedge clk);
        n_checks++; if (tgq.size() != 4) $display("FAIL single_toggles: got %0d want 4", tgq.size()); else n_pass++;
        if (tgq.size() == 4) begin
            n_checks++; if (tgq[0].c - p != 2) $display("FAIL single_first_strobe: got %0d want 2", tgq[0].c - p); else n_pass++;
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (tgq[i].d[1:0] !== exp_sym[i]) $display("FAIL single_sym%0d: got %b want %b", i, tgq[i].d[1:0], exp_sym[i]); else n_pass++;
            end
            for (int i = 1; i < 4; i++) begin
                n_checks++; if (tgq[i].c - tgq[i-1].c != 6) $display("FAIL single_spacing%0d: got %0d want 6", i, tgq[i].c - tgq[i-1].c); else n_pass++;
            end
        end
        n_checks++; if (rxq.size() != 1) $display("FAIL single_rx_count: got %0d want 1", rxq.size()); else n_pass++;
        if (rxq.size() == 1) begin
            n_checks++; if (rxq[0].d !== 8'hA5) $display("FAIL single_rx_data: got %h want a5", rxq[0].d); else n_pass++;
            if (tgq.size() == 4) begin
                n_checks++; if (rxq[0].c - tgq[3].c != 3) $display("FAIL single_rx_latency: got %0d want 3", rxq[0].c - tgq[3].c); else n_pass++;
            end
        end
        n_checks++; if (errq.size() != 0) $display("FAIL single_rx_err: got %0d want 0", errq.size()); else n_pass++;
        n_checks++; if (link_busy !== 1'b0) $display("FAIL single_idle_busy: got %b want 0", link_busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        int p;
        clear_mon();
        for (int i = 0; i < 5; i++) push(exp_b[i], p);
        n_checks++; if (tx_ready !== 1'b0) $display("FAIL b2b_full_ready: got %b want 0", tx_ready); else n_pass++;
        n_checks++; if (link_busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", link_busy); else n_pass++;
        // Offer one more byte while full; it must be refused.
        tx_data = 8'h66;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_rx(5, 200);
        repeat (40) @(negedge clk);
        n_checks++; if (rxq.size() != 5) $display("FAIL b2b_rx_count: got %0d want 5", rxq.size()); else n_pass++;
        if (rxq.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                n_checks++; if (rxq[i].d !== exp_b[i]) $display("FAIL b2b_data%0d: got %h want %h", i, rxq[i].d, exp_b[i]); else n_pass++;
            end
            for (int i = 1; i < 5; i++) begin
                n_checks++; if (rxq[i].c - rxq[i-1].c != 24) $display("FAIL b2b_spacing%0d: got %0d want 24", i, rxq[i].c - rxq[i-1].c); else n_pass++;
            end
        end
        n_checks++; if (errq.size() != 0) $display("FAIL b2b_rx_err: got %0d want 0", errq.size()); else n_pass++;
        n_checks++; if ({tx_ready, link_busy} !== 2'b10) $display("FAIL b2b_drained: got %b want 10", {tx_ready, link_busy}); else n_pass++;
    endtask

    task automatic test_timeout();
        int t1, t2;
        int k = 0;
        drv = 3'b000;
        loop_en = 1'b0;
        repeat (5) @(negedge clk);
        clear_mon();
        send_sym(2'b01, t1);
        send_sym(2'b10, t2);
        while (errq.size() < 1 && k < 120) begin
            @(negedge clk); k++;
        end
        n_checks++; if (errq.size() != 1) $display("FAIL to_err_count: got %0d want 1", errq.size()); else n_pass++;
        if (errq.size() == 1) begin
            n_checks++; if (errq[0] - t2 != TO + 3) $display("FAIL to_err_time: got %0d want %0d", errq[0] - t2, TO + 3); else n_pass++;
        end
        n_checks++; if (rxq.size() != 0) $display("FAIL to_no_rx: got %0d want 0", rxq.size()); else n_pass++;
        send_sym(2'b00, t1);
        send_sym(2'b11, t1);
        send_sym(2'b11, t1);
        send_sym(2'b00, t1);
        n_checks++; if (rxq.size() != 1) $display("FAIL to_rx_count: got %0d want 1", rxq.size()); else n_pass++;
        if (rxq.size() == 1) begin
            n_checks++; if (rxq[0].d !== 8'h3C) $display("FAIL to_rx_data: got %h want 3c", rxq[0].d); else n_pass++;
        end
        n_checks++; if (errq.size() != 1) $display("FAIL to_no_extra_err: got %0d want 1", errq.size()); else n_pass++;
    endtask

    task automatic test_no_strobe();
        clear_mon();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); drv[1:0] = 2'(i + 1);
        end
        repeat (TO + 20) @(negedge clk);
        n_checks++; if (rxq.size() != 0) $display("FAIL nostrobe_rx: got %0d want 0", rxq.size()); else n_pass++;
        n_checks++; if (errq.size() != 0) $display("FAIL nostrobe_err: got %0d want 0", errq.size()); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        int p, p2;
        loop_en = 1'b1;
        repeat (5) @(negedge clk);
        clear_mon();
        push(8'hF0, p);
        push(8'h99, p2);
        tx_valid = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++; if (dialogue_out !== 3'b111) $display("FAIL mid_sym2: got %b want 111", dialogue_out); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (dialogue_out !== 3'b000) $display("FAIL mid_rst_out: got %b want 000", dialogue_out); else n_pass++;
        n_checks++; if ({tx_ready, link_busy, rx_valid, rx_err} !== 4'b1000) $display("FAIL mid_rst_flags: got %b want 1000", {tx_ready, link_busy, rx_valid, rx_err}); else n_pass++;
        n_checks++; if (rx_data !== 8'h00) $display("FAIL mid_rst_rx_data: got %h want 00", rx_data); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (TO + 30) @(negedge clk);
        n_checks++; if (errq.size() > 1) $display("FAIL mid_err_count: got %0d want <=1", errq.size()); else n_pass++;
        n_checks++; if (rxq.size() != 0) $display("FAIL mid_abandoned: got %0d want 0", rxq.size()); else n_pass++;
        clear_mon();
        push(8'h0F, p);
        tx_valid = 1'b0;
        wait_rx(1, 100);
        repeat (10) @(negedge clk);
        n_checks++; if (rxq.size() != 1) $display("FAIL mid_next_count: got %0d want 1", rxq.size()); else n_pass++;
        if (rxq.size() == 1) begin
            n_checks++; if (rxq[0].d !== 8'h0F) $display("FAIL mid_next_data: got %h want 0f", rxq[0].d); else n_pass++;
        end
        n_checks++; if (errq.size() != 0) $display("FAIL mid_next_err: got %0d want 0", errq.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_no_strobe();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
